// File: rtl/marquee_pkg.sv
// Shared constants for the marquee loader: FSM encodings, display word layout
// and the ASCII ranges the glyph encoder folds into 6-bit glyph codes.
package marquee_pkg;

  localparam int WORD_W = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam logic [WORD_W-1:0] BLANK = 7'h40;

  localparam logic [7:0] ASCII_LO    = 8'h20;
  localparam logic [7:0] ASCII_LOWER = 8'h60;
  localparam logic [7:0] ASCII_END   = 8'h80;
  localparam logic [7:0] FOLD_OFS    = 8'h40;

endpackage

// File: rtl/glyph_encode.sv
// Combinational ASCII-to-display-word encoder; lower case folds onto upper
// case glyphs, control and non-ASCII codes become BLANK.
module glyph_encode
  import marquee_pkg::*;
(
  input  logic [7:0]        ch_data_i,
  input  logic              ch_raw_i,
  output logic [WORD_W-1:0] word_o
);

  // Only the low 6 bits of the difference matter, so the subtraction is done at 6 bits.
  always_comb begin
    word_o = BLANK;
    if (ch_raw_i) begin
      word_o = {1'b0, ch_data_i[5:0]};
    end else if (ch_data_i < ASCII_LO) begin
      word_o = BLANK;
    end else if (ch_data_i < ASCII_LOWER) begin
      word_o = {1'b1, ch_data_i[5:0] - ASCII_LO[5:0]};
    end else if (ch_data_i < ASCII_END) begin
      word_o = {1'b1, ch_data_i[5:0] - FOLD_OFS[5:0]};
    end else begin
      word_o = BLANK;
    end
  end

endmodule

// File: rtl/marquee_loader.sv
// Collects a message over a valid/ready handshake, then re-syncs the display
// word counter and streams every word serially so message word 0 lands at display word 0.
module marquee_loader
  import marquee_pkg::*;
#(
  parameter int WORD_COUNT = 30
)
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ch_valid_i,
  input  logic [7:0] ch_data_i,
  input  logic       ch_raw_i,
  output logic       ch_ready_o,
  input  logic       commit_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       disp_reset_o,
  output logic       disp_write_o,
  output logic       disp_din_o
);

  localparam int CNT_W = $clog2(WORD_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_COUNT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  slot_q, slot_d;
  logic [2:0]        bit_q, bit_d;
  logic [WORD_W-1:0] store_q [WORD_COUNT];

  logic ch_ready_q, busy_q, done_q, disp_reset_q, disp_write_q, disp_din_q;
  logic ch_ready_d, busy_d, done_d, disp_reset_d, disp_write_d, disp_din_d;

  logic              accept_s;
  logic [WORD_W-1:0] enc_word_s;
  logic [CNT_W-1:0]  idx_s;
  logic [WORD_W-1:0] word_s;

  glyph_encode u_glyph_encode (
    .ch_data_i (ch_data_i),
    .ch_raw_i  (ch_raw_i),
    .word_o    (enc_word_s)
  );

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    slot_d   = slot_q;
    bit_d    = bit_q;
    done_d   = 1'b0;
    accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept_s = ch_valid_i && ch_ready_q;
        if (accept_s) begin
          wr_cnt_d = wr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
        if (commit_i) begin
          state_d = ST_SYNC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SYNC: begin
        state_d = ST_SHIFT;
        slot_d  = '0;
        bit_d   = 3'd0;
      end
      ST_SHIFT: begin
        if (bit_q == 3'd7) begin
          bit_d = 3'd0;
          if (slot_q == CNT_LAST) begin
            state_d  = ST_IDLE;
            slot_d   = '0;
            wr_cnt_d = '0;
            done_d   = 1'b1;
          end else begin
            slot_d = slot_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          bit_d = bit_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Slot 0 carries the last message index so the display's rotation ends with index 0 in front.
  always_comb begin
    if (slot_d == '0) begin
      idx_s = CNT_LAST;
    end else begin
      idx_s = slot_d - {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (idx_s < wr_cnt_q) begin
      word_s = store_q[idx_s];
    end else begin
      word_s = BLANK;
    end
  end

  always_comb begin
    ch_ready_d   = (state_d == ST_IDLE) && (wr_cnt_d < CNT_FULL);
    busy_d       = (state_d != ST_IDLE);
    disp_reset_d = (state_d == ST_SYNC);
    disp_write_d = (state_d == ST_SHIFT);
    if ((state_d == ST_SHIFT) && (bit_d != 3'd7)) begin
      disp_din_d = word_s[bit_d];
    end else begin
      disp_din_d = 1'b0;
    end
  end

  // Message contents are qualified by wr_cnt, so the store itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (accept_s) begin
      store_q[wr_cnt_q] <= enc_word_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= '0;
      slot_q       <= '0;
      bit_q        <= 3'd0;
      ch_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      disp_reset_q <= 1'b1;
      disp_write_q <= 1'b0;
      disp_din_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      slot_q       <= slot_d;
      bit_q        <= bit_d;
      ch_ready_q   <= ch_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      disp_reset_q <= disp_reset_d;
      disp_write_q <= disp_write_d;
      disp_din_q   <= disp_din_d;
    end
  end

  assign ch_ready_o   = ch_ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign disp_reset_o = disp_reset_q;
  assign disp_write_o = disp_write_q;
  assign disp_din_o   = disp_din_q;

endmodule

// File: tb/tb_marquee_loader.sv
// Directed bench for marquee_loader: encodes messages, deserialises the
// stream into a display model and compares each display word with hand-computed values.
module tb_marquee_loader;

  localparam int WC = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data = 8'h00;
  logic       ch_raw = 1'b0;
  logic       commit = 1'b0;
  logic       ch_ready, busy, done, disp_reset, disp_write, disp_din;

  int checks = 0;
  int errors = 0;

  logic [6:0] disp_mem [WC];
  logic [6:0] exp_msg [$];

  typedef struct {
    logic [7:0] data;
    logic       raw;
    logic [6:0] word;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  marquee_loader #(.WORD_COUNT(WC)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ch_valid_i   (ch_valid),
    .ch_data_i    (ch_data),
    .ch_raw_i     (ch_raw),
    .ch_ready_o   (ch_ready),
    .commit_i     (commit),
    .busy_o       (busy),
    .done_o       (done),
    .disp_reset_o (disp_reset),
    .disp_write_o (disp_write),
    .disp_din_o   (disp_din)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk7(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 7'h%02h, expected 7'h%02h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk1({tag, "_ch_ready"}, ch_ready, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_disp_reset"}, disp_reset, 1'b1);
    chk1({tag, "_disp_write"}, disp_write, 1'b0);
    chk1({tag, "_disp_din"}, disp_din, 1'b0);
  endtask

  // Called at a negedge; returns at the following negedge with ch_valid dropped.
  task automatic send_char(input logic [7:0] d, input logic raw);
    chk1("ready_before_send", ch_ready, 1'b1);
    ch_valid = 1'b1;
    ch_data  = d;
    ch_raw   = raw;
    @(negedge clk);
    ch_valid = 1'b0;
    ch_raw   = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic with_char, input logic [7:0] d);
    logic       wr_ok;
    logic       b7_ok;
    logic [6:0] w;
    logic [6:0] e;
    wr_ok  = 1'b1;
    b7_ok  = 1'b1;
    commit = 1'b1;
    if (with_char) begin
      ch_valid = 1'b1;
      ch_data  = d;
      ch_raw   = 1'b0;
    end
    @(negedge clk);
    commit   = 1'b0;
    ch_valid = 1'b0;
    chk1({tag, "_sync_busy"}, busy, 1'b1);
    chk1({tag, "_sync_disp_reset"}, disp_reset, 1'b1);
    chk1({tag, "_sync_disp_write"}, disp_write, 1'b0);
    chk1({tag, "_sync_ch_ready"}, ch_ready, 1'b0);
    for (int s = 0; s < WC; s++) begin
      w = 7'h00;
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        if (disp_write !== 1'b1 || busy !== 1'b1 || disp_reset !== 1'b0) wr_ok = 1'b0;
        if (b < 7) w[b] = disp_din;
        else if (disp_din !== 1'b0) b7_ok = 1'b0;
      end
      disp_mem[(s + WC - 1) % WC] = w;
    end
    chk1({tag, "_write_every_shift_cycle"}, wr_ok, 1'b1);
    chk1({tag, "_bit7_zero"}, b7_ok, 1'b1);
    @(negedge clk);
    chk1({tag, "_done_pulse"}, done, 1'b1);
    chk1({tag, "_done_busy"}, busy, 1'b0);
    chk1({tag, "_done_disp_write"}, disp_write, 1'b0);
    chk1({tag, "_done_ch_ready"}, ch_ready, 1'b1);
    @(negedge clk);
    chk1({tag, "_done_clears"}, done, 1'b0);
    for (int m = 0; m < WC; m++) begin
      e = (m < exp_msg.size()) ? exp_msg[m] : 7'h40;
      chk7({tag, "_word"}, m, disp_mem[m], e);
    end
    exp_msg.delete();
  endtask

  initial begin
    vecs[0]  = '{8'h41, 1'b0, 7'h61};
    vecs[1]  = '{8'h7A, 1'b0, 7'h7A};
    vecs[2]  = '{8'h21, 1'b0, 7'h41};
    vecs[3]  = '{8'h20, 1'b0, 7'h40};
    vecs[4]  = '{8'h5F, 1'b0, 7'h7F};
    vecs[5]  = '{8'h60, 1'b0, 7'h60};
    vecs[6]  = '{8'h7F, 1'b0, 7'h7F};
    vecs[7]  = '{8'h1F, 1'b0, 7'h40};
    vecs[8]  = '{8'h00, 1'b0, 7'h40};
    vecs[9]  = '{8'h3F, 1'b1, 7'h3F};
    vecs[10] = '{8'hC5, 1'b1, 7'h05};
    vecs[11] = '{8'h30, 1'b0, 7'h50};

    // Reset state and release.
    @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk1("release_disp_reset", disp_reset, 1'b0);
    chk1("release_ch_ready", ch_ready, 1'b1);
    chk1("release_disp_write", disp_write, 1'b0);

    // "Az!"
    send_char(8'h41, 1'b0); exp_msg.push_back(7'h61);
    send_char(8'h7A, 1'b0); exp_msg.push_back(7'h7A);
    send_char(8'h21, 1'b0); exp_msg.push_back(7'h41);
    run_load("az", 1'b0, 8'h00);

    // Raw column word.
    send_char(8'h3F, 1'b1); exp_msg.push_back(7'h3F);
    run_load("raw", 1'b0, 8'h00);

    // Encoding table.
    for (int i = 0; i < 12; i++) begin
      send_char(vecs[i].data, vecs[i].raw);
      exp_msg.push_back(vecs[i].word);
    end
    run_load("table", 1'b0, 8'h00);

    // Full store, then a rejected 31st character.
    for (int i = 0; i < WC; i++) begin
      send_char(8'h41 + 8'(i), 1'b0);
      exp_msg.push_back(7'h61 + 7'(i));
    end
    chk1("full_ch_ready_low", ch_ready, 1'b0);
    ch_valid = 1'b1;
    ch_data  = 8'h30;
    @(negedge clk);
    ch_valid = 1'b0;
    chk1("full_stays_not_ready", ch_ready, 1'b0);
    run_load("full", 1'b0, 8'h00);

    // Character accepted in the same cycle as commit, from an empty store.
    exp_msg.push_back(7'h62);
    run_load("simul", 1'b1, 8'h42);

    // Reset in the middle of slot 10, then a clean load.
    send_char(8'h48, 1'b0);
    send_char(8'h49, 1'b0);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    repeat (83) @(negedge clk);
    chk1("midload_busy_before_reset", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midload_reset");
    @(negedge clk);
    check_reset_values("midload_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk1("midload_release_disp_reset", disp_reset, 1'b0);
    chk1("midload_release_ch_ready", ch_ready, 1'b1);
    chk1("midload_release_busy", busy, 1'b0);
    send_char(8'h68, 1'b0); exp_msg.push_back(7'h68);
    run_load("after_reset", 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
